// File: rtl/lsu_ctrl_if.sv
// Request/response and data-memory signal bundle for lsu_ctrl.
// slave is the controller's view; master is the core/memory side.
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_sel;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_we, req_sel, req_addr, req_wdata, mem_rdata, mem_ack,
    output req_ready, mem_en, mem_we, mem_addr, mem_be, mem_wdata,
           rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_we, req_sel, req_addr, req_wdata, mem_rdata, mem_ack,
    input  req_ready, mem_en, mem_we, mem_addr, mem_be, mem_wdata,
           rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store controller: lane steering, memory handshake with timeout, extended load return.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of ignoring low bits.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  lsu_ctrl_if.slave  bus,
  output logic       busy
);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned SW = 3;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [1:0]    off_q, off_d;
  logic          we_q, we_d;

  logic          req_ready_q, req_ready_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [BW-1:0] mem_be_q, mem_be_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          busy_q, busy_d;

  logic          is_byte, is_half, trap;
  logic [1:0]    req_off;
  logic [BW-1:0] st_be;
  logic [DW-1:0] st_wdata;
  logic [DW-1:0] ld_shift, ld_ext;

  // Request decode: lane offset, store lane mask/replication, misalignment
  always_comb begin
    is_byte  = (bus.req_sel == 3'b000) || (bus.req_sel == 3'b011);
    is_half  = (bus.req_sel == 3'b001) || (bus.req_sel == 3'b100);
    req_off  = 2'b00;
    st_be    = 4'b1111;
    st_wdata = bus.req_wdata;
    if (is_byte) begin
      req_off  = bus.req_addr[1:0];
      st_be    = 4'b0001 << req_off;
      st_wdata = {4{bus.req_wdata[7:0]}};
    end else if (is_half) begin
      req_off  = {bus.req_addr[1], 1'b0};
      st_be    = 4'b0011 << req_off;
      st_wdata = {2{bus.req_wdata[15:0]}};
    end
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (is_half && bus.req_addr[0]) ||
           (!is_byte && !is_half && (bus.req_addr[1:0] != 2'b00));
`else
    trap = 1'b0;
`endif
  end

  // Load extraction from the captured lane offset and size
  always_comb begin
    ld_shift = bus.mem_rdata >> {off_q, 3'b000};
    case (sel_q)
      3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b011:  ld_ext = {24'h0, ld_shift[7:0]};
      3'b100:  ld_ext = {16'h0, ld_shift[15:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  // Next state; outputs are registered images of the next state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    off_d       = off_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_data_d  = '0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          sel_d       = bus.req_sel;
          off_d       = req_off;
          we_d        = bus.req_we;
          mem_addr_d  = {bus.req_addr[31:2], 2'b00};
          mem_be_d    = bus.req_we ? st_be : 4'b1111;
          mem_wdata_d = st_wdata;
          cnt_d       = '0;
          state_d     = trap ? ERR : ACCESS;
        end
      end
      ACCESS: begin
        if (bus.mem_ack) begin
          state_d    = RESP;
          rsp_data_d = we_q ? '0 : ld_ext;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    mem_en_d    = (state_d == ACCESS);
    mem_we_d    = mem_en_d && we_d;
    rsp_valid_d = (state_d == RESP) || (state_d == ERR);
    rsp_err_d   = (state_d == ERR);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      off_q       <= '0;
      we_q        <= 1'b0;
      req_ready_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      off_q       <= off_d;
      we_q        <= we_d;
      req_ready_q <= req_ready_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_data  = rsp_data_q;
  assign busy          = busy_q;
endmodule
